// File: rtl/psm_carrier_gen.sv
// Square-wave PSM generator: free-running period counter with duty compare and phase
// offset; new settings are taken through a pending register and applied at period boundaries.
module psm_carrier_gen #(
    parameter int BITS_DATA = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 iEN,
    input  logic [BITS_DATA-1:0] iPERIOD,
    input  logic [BITS_DATA-1:0] iDUTY,
    input  logic [BITS_DATA-1:0] iPHASE,
    input  logic                 iLOAD,
    output logic                 oPSM,
    output logic                 oSYNC,
    output logic                 oACK,
    output logic                 oPEND
);

    logic [BITS_DATA-1:0] r_per_p, r_duty_p, r_ph_p;
    logic [BITS_DATA-1:0] r_per_a, r_duty_a, r_ph_a;
    logic [BITS_DATA-1:0] r_cnt;
    logic                 r_pend;
    logic                 r_psm, r_sync, r_ack;

    logic [BITS_DATA-1:0] w_ph_in;
    logic                 w_last;
    logic                 w_run;
    logic                 w_boundary;
    logic                 w_apply;
    logic [BITS_DATA:0]   w_sum;
    logic [BITS_DATA:0]   w_pos;

    // A phase that is not below the period is meaningless, so it collapses to 0.
    assign w_ph_in    = (iPHASE >= iPERIOD) ? '0 : iPHASE;
    assign w_run      = iEN && (r_per_a != '0);
    assign w_last     = (r_cnt == (r_per_a - BITS_DATA'(1)));
    assign w_boundary = !iEN || (r_per_a == '0) || w_last;
    assign w_apply    = w_boundary && (iLOAD || r_pend);

    assign w_sum = {1'b0, r_cnt} + {1'b0, r_ph_a};
    assign w_pos = (w_sum >= {1'b0, r_per_a}) ? (w_sum - {1'b0, r_per_a}) : w_sum;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_per_p  <= '0;
            r_duty_p <= '0;
            r_ph_p   <= '0;
            r_pend   <= 1'b0;
        end else if (w_apply) begin
            r_pend <= 1'b0;
        end else if (iLOAD) begin
            r_per_p  <= iPERIOD;
            r_duty_p <= iDUTY;
            r_ph_p   <= w_ph_in;
            r_pend   <= 1'b1;
        end
    end

    // A load landing on a boundary bypasses the pending set entirely.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_per_a  <= '0;
            r_duty_a <= '0;
            r_ph_a   <= '0;
        end else if (w_apply) begin
            if (iLOAD) begin
                r_per_a  <= iPERIOD;
                r_duty_a <= iDUTY;
                r_ph_a   <= w_ph_in;
            end else begin
                r_per_a  <= r_per_p;
                r_duty_a <= r_duty_p;
                r_ph_a   <= r_ph_p;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_apply || !w_run || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + BITS_DATA'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_psm  <= 1'b0;
            r_sync <= 1'b0;
            r_ack  <= 1'b0;
        end else begin
            r_psm  <= w_run && (w_pos < {1'b0, r_duty_a});
            r_sync <= w_run && (r_cnt == '0);
            r_ack  <= w_apply;
        end
    end

    assign oPSM  = r_psm;
    assign oSYNC = r_sync;
    assign oACK  = r_ack;
    assign oPEND = r_pend;

endmodule
